// File: rtl/cla_pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cla_pkg
// Brief    : Shared constants, 4-bit lookahead group function and parameter check
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int GRP_W = 4;

    typedef struct packed {
        logic [GRP_W-1:0] sum;
        logic             cout;
    } grp_res_t;

    // Carries are fully expanded from p/g/c0; no ripple inside the group.
    function automatic grp_res_t cla4(
        input logic [GRP_W-1:0] p,
        input logic [GRP_W-1:0] g,
        input logic             c0
    );
        grp_res_t       res;
        logic [GRP_W:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        res.sum  = p ^ c[GRP_W-1:0];
        res.cout = c[GRP_W];
        return res;
    endfunction

    function automatic bit width_ok(input int width, input int gps);
        return (gps > 0) && (width > 0) && ((width % (GRP_W * gps)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_pipe_adder_grp4.sv
`default_nettype none
// ============================================================================
// Module   : cla_grp4
// Brief    : Combinational 4-bit carry-lookahead group with group P/G outputs
// Revision : 1.0 - initial release
// ============================================================================
module cla_grp4
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             cin,
    output logic [GRP_W-1:0] sum,
    output logic             cout,
    output logic             gp,
    output logic             gg
);

    logic [GRP_W-1:0] w_p;
    logic [GRP_W-1:0] w_g;
    grp_res_t         w_res;

    assign w_p   = a ^ b;
    assign w_g   = a & b;
    assign w_res = cla4(w_p, w_g, cin);
    assign sum   = w_res.sum;
    assign cout  = w_res.cout;

    // Group P/G are independent of cin so the stage lookahead has no loop.
    assign gp = &w_p;
    assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Brief    : Pipelined, skewed carry-lookahead adder/subtractor with valid/ready
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / (GRP_W * GPS);
    localparam int c_sw = GRP_W * GPS;

    if (!width_ok(WIDTH, GPS)) begin : g_chk_width
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4*GPS");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_bb;
    logic             w_c0;

    assign w_bb     = sub ? ~b : b;
    assign w_c0     = sub | cin;
    assign w_adv    = !out_valid | out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int c_lo = c_sw * k;
        localparam int c_hi = c_sw * (k + 1);

        logic [c_sw-1:0] w_a_grp;
        logic [c_sw-1:0] w_b_grp;
        logic [c_sw-1:0] w_s;
        logic            w_c_in;
        logic            w_v_in;
        logic [c_hi-1:0] w_sum_nx;
        logic [GPS:0]    w_gc;
        logic [GPS-1:0]  w_gp;
        logic [GPS-1:0]  w_gg;
        logic [GPS-1:0]  w_grp_co;
        logic            w_unused_co;

        logic            r_v;
        logic            r_c;
        logic [c_hi-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_a_grp  = a[c_sw-1:0];
            assign w_b_grp  = w_bb[c_sw-1:0];
            assign w_c_in   = w_c0;
            assign w_v_in   = in_valid;
            assign w_sum_nx = w_s;
        end else begin : g_src
            assign w_a_grp  = g_stg[k-1].g_ops.r_a[c_sw-1:0];
            assign w_b_grp  = g_stg[k-1].g_ops.r_b[c_sw-1:0];
            assign w_c_in   = g_stg[k-1].r_c;
            assign w_v_in   = g_stg[k-1].r_v;
            assign w_sum_nx = {w_s, g_stg[k-1].r_sum};
        end

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_grp4 u_grp (
                .a    (w_a_grp[GRP_W*j +: GRP_W]),
                .b    (w_b_grp[GRP_W*j +: GRP_W]),
                .cin  (w_gc[j]),
                .sum  (w_s[GRP_W*j +: GRP_W]),
                .cout (w_grp_co[j]),
                .gp   (w_gp[j]),
                .gg   (w_gg[j])
            );
        end

        // Group ripple-outs duplicate the lookahead carries below.
        assign w_unused_co = ^w_grp_co;

        // Expanded lookahead across the groups: c[j+1] = OR of gg[m]&gp[j:m+1], plus gp[j:0]&c0.
        always_comb begin
            logic v_pacc;
            logic v_term;
            w_gc    = '0;
            w_gc[0] = w_c_in;
            for (int j = 0; j < GPS; j++) begin
                v_pacc = 1'b1;
                v_term = 1'b0;
                for (int m = j; m >= 0; m--) begin
                    v_term = v_term | (v_pacc & w_gg[m]);
                    v_pacc = v_pacc & w_gp[m];
                end
                w_gc[j+1] = v_term | (v_pacc & w_c_in);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_v   <= w_v_in;
                r_c   <= w_gc[GPS];
                r_sum <= w_sum_nx;
            end
        end

        if (k < NSTG - 1) begin : g_ops
            localparam int c_rem = WIDTH - c_hi;
            logic [c_rem-1:0] w_a_nx;
            logic [c_rem-1:0] w_b_nx;
            logic [c_rem-1:0] r_a;
            logic [c_rem-1:0] r_b;

            if (k == 0) begin : g_rsrc
                assign w_a_nx = a[WIDTH-1:c_hi];
                assign w_b_nx = w_bb[WIDTH-1:c_hi];
            end else begin : g_rsrc
                assign w_a_nx = g_stg[k-1].g_ops.r_a[WIDTH-c_lo-1:c_sw];
                assign w_b_nx = g_stg[k-1].g_ops.r_b[WIDTH-c_lo-1:c_sw];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_nx;
                    r_b <= w_b_nx;
                end
            end
        end else begin : g_last
            logic r_ovf;
            // Carry into the MSB is recovered as s ^ p at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_gc[GPS] ^ w_s[c_sw-1] ^ w_a_grp[c_sw-1] ^ w_b_grp[c_sw-1];
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].r_v;
    assign sum       = g_stg[NSTG-1].r_sum;
    assign cout      = g_stg[NSTG-1].r_c;
    assign ovf       = g_stg[NSTG-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe_adder
// Brief    : Directed-vector self-checking bench for cla_pipe_adder (16/1, 32/2, 8/2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Default instance: WIDTH=16, GPS=1, NSTG=4
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    // WIDTH=32, GPS=2, NSTG=4
    logic        in_valid_32, in_ready_32, cin_32, sub_32, out_valid_32, out_ready_32, cout_32, ovf_32;
    logic [31:0] a_32, b_32, sum_32;

    // WIDTH=8, GPS=2, NSTG=1
    logic        in_valid_8, in_ready_8, cin_8, sub_8, out_valid_8, out_ready_8, cout_8, ovf_8;
    logic [7:0]  a_8, b_8, sum_8;

    cla_pipe_adder u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_pipe_adder #(.WIDTH(32), .GPS(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_32), .in_ready(in_ready_32),
        .a(a_32), .b(b_32), .cin(cin_32), .sub(sub_32), .out_valid(out_valid_32),
        .out_ready(out_ready_32), .sum(sum_32), .cout(cout_32), .ovf(ovf_32)
    );

    cla_pipe_adder #(.WIDTH(8), .GPS(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .cin(cin_8), .sub(sub_8), .out_valid(out_valid_8),
        .out_ready(out_ready_8), .sum(sum_8), .cout(cout_8), .ovf(ovf_8)
    );

    // Vector tables, loaded by each task
    logic [15:0] va[8], vb[8], es[8];
    logic        vc[8], vs[8], ec[8], eo[8];
    logic [31:0] wa[6], wb[6], ws[6];
    logic        wc[6], wsub[6], wec[6], weo[6];
    logic [7:0]  xa[7], xb[7], xs[7];
    logic        xc[7], xsub[7], xec[7], xeo[7];

    task automatic drive16(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic isub);
        in_valid = 1'b1; a = ia; b = ib; cin = ic; sub = isub;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hold: got valid=%b sum=%h cout=%b ovf=%b in_ready=%b, expected 0 0000 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        n_tests++;
        if ({out_valid_32, sum_32, out_valid_8, sum_8} !== {1'b0, 32'h0, 1'b0, 8'h0}) begin
            n_fail++;
            $display("FAIL reset_hold_sweep: got v32=%b s32=%h v8=%b s8=%h, expected all zero",
                     out_valid_32, sum_32, out_valid_8, sum_8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        drive16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL add_latency: got %0d cycles, expected 4", lat);
        end
        n_tests++;
        if ({sum, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ffff_1: got sum=%h cout=%b ovf=%b, expected 0000 1 0", sum, cout, ovf);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sub();
        @(negedge clk);
        drive16(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            n_tests++;
            if (t == 4) begin
                if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL sub_8000_1: got valid=%b sum=%h cout=%b ovf=%b, expected 1 7fff 1 1",
                             out_valid, sum, cout, ovf);
                end
            end else if (t == 5) begin
                if ({out_valid, sum, cout, ovf} !== {1'b1, 16'hFFFF, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL sub_1_2: got valid=%b sum=%h cout=%b ovf=%b, expected 1 ffff 0 0",
                             out_valid, sum, cout, ovf);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sub_idle_t%0d: got valid=%b, expected 0", t, out_valid);
            end
            if (t == 1) drive16(16'h0001, 16'h0002, 1'b1, 1'b1);
            else        in_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        va = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h00FF, 16'h9000};
        vb = '{16'h4321, 16'h7FFF, 16'hFFFF, 16'h8000, 16'hF0F0, 16'h1111, 16'h0001, 16'hA000};
        vc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        es = '{16'h5555, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hBCDE, 16'h0101, 16'h3000};
        ec = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        drive16(va[0], vb[0], vc[0], 1'b0);
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            n_tests++;
            if (t >= 4 && t < 12) begin
                if ({out_valid, sum, cout, ovf} !== {1'b1, es[t-4], ec[t-4], eo[t-4]}) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got valid=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                             t-4, out_valid, sum, cout, ovf, es[t-4], ec[t-4], eo[t-4]);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle_t%0d: got valid=%b, expected 0", t, out_valid);
            end
            if (t < 8) drive16(va[t], vb[t], vc[t], 1'b0);
            else       in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        va = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0};
        vb = '{16'h0001, 16'h0020, 16'h0300, 16'h3000, 16'h0, 16'h0, 16'h0, 16'h0};
        es = '{16'h0002, 16'h0030, 16'h0400, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0};
        @(negedge clk);
        drive16(va[0], vb[0], 1'b0, 1'b0);
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            drive16(va[t], vb[t], 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, sum} !== {1'b1, es[0]}) begin
            n_fail++;
            $display("FAIL bp_head: got valid=%b sum=%h, expected 1 %h", out_valid, sum, es[0]);
        end
        out_ready = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready_s%0d: got %b, expected 0", s, in_ready);
            end
            n_tests++;
            if ({out_valid, sum, cout, ovf} !== {1'b1, es[0], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_stable_s%0d: got valid=%b sum=%h cout=%b ovf=%b, expected 1 %h 0 0",
                         s, out_valid, sum, cout, ovf, es[0]);
            end
        end
        out_ready = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            n_tests++;
            if (t < 4) begin
                if ({out_valid, sum} !== {1'b1, es[t]}) begin
                    n_fail++;
                    $display("FAIL bp_drain_%0d: got valid=%b sum=%h, expected 1 %h", t, out_valid, sum, es[t]);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_drain_end: got valid=%b, expected 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        drive16(16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
        @(negedge clk);
        drive16(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        @(negedge clk);
        drive16(16'h0001, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, sum, cout, ovf} !== {1'b1, 16'hFFFD, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_pre: got valid=%b sum=%h cout=%b ovf=%b, expected 1 fffd 1 0",
                     out_valid, sum, cout, ovf);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b sum=%h cout=%b ovf=%b in_ready=%b, expected 0 0000 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_tests++;
            if (t == 4) begin
                if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rst_after: got valid=%b sum=%h cout=%b ovf=%b, expected 1 8000 0 1",
                             out_valid, sum, cout, ovf);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale_t%0d: got valid=%b sum=%h, expected valid 0", t, out_valid, sum);
            end
        end
    endtask

    task automatic test_sweep32();
        wa   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h7FFFFFFF, 32'h00010000, 32'h89ABCDEF};
        wb   = '{32'hFFFFFFFF, 32'h00000000, 32'h87654321, 32'h00000001, 32'h00000001, 32'h76543210};
        wc   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        wsub = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ws   = '{32'hFFFFFFFF, 32'h00000000, 32'h8ACF1357, 32'h80000000, 32'h0000FFFF, 32'hFFFFFFFF};
        wec  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        weo  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        in_valid_32 = 1'b1; a_32 = wa[0]; b_32 = wb[0]; cin_32 = wc[0]; sub_32 = wsub[0];
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            n_tests++;
            if (t >= 4 && t < 10) begin
                if ({out_valid_32, sum_32, cout_32, ovf_32} !== {1'b1, ws[t-4], wec[t-4], weo[t-4]}) begin
                    n_fail++;
                    $display("FAIL w32_%0d: got valid=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                             t-4, out_valid_32, sum_32, cout_32, ovf_32, ws[t-4], wec[t-4], weo[t-4]);
                end
            end else if (out_valid_32 !== 1'b0) begin
                n_fail++;
                $display("FAIL w32_idle_t%0d: got valid=%b, expected 0", t, out_valid_32);
            end
            if (t < 6) begin
                a_32 = wa[t]; b_32 = wb[t]; cin_32 = wc[t]; sub_32 = wsub[t];
            end else begin
                in_valid_32 = 1'b0;
            end
        end
    endtask

    task automatic test_sweep8();
        xa   = '{8'hFF, 8'h7F, 8'h80, 8'h00, 8'h0F, 8'hA5, 8'h05};
        xb   = '{8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h5A, 8'h03};
        xc   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        xsub = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        xs   = '{8'hFF, 8'h80, 8'h7F, 8'hFF, 8'h11, 8'h00, 8'h02};
        xec  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        xeo  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        in_valid_8 = 1'b1; a_8 = xa[0]; b_8 = xb[0]; cin_8 = xc[0]; sub_8 = xsub[0];
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            n_tests++;
            if (t < 8) begin
                if ({out_valid_8, sum_8, cout_8, ovf_8} !== {1'b1, xs[t-1], xec[t-1], xeo[t-1]}) begin
                    n_fail++;
                    $display("FAIL w8_%0d: got valid=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                             t-1, out_valid_8, sum_8, cout_8, ovf_8, xs[t-1], xec[t-1], xeo[t-1]);
                end
            end else if (out_valid_8 !== 1'b0) begin
                n_fail++;
                $display("FAIL w8_idle: got valid=%b, expected 0", out_valid_8);
            end
            if (t < 7) begin
                a_8 = xa[t]; b_8 = xb[t]; cin_8 = xc[t]; sub_8 = xsub[t];
            end else begin
                in_valid_8 = 1'b0;
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid_32 = 1'b0; a_32 = '0; b_32 = '0; cin_32 = 1'b0; sub_32 = 1'b0; out_ready_32 = 1'b1;
        in_valid_8 = 1'b0; a_8 = '0; b_8 = '0; cin_8 = 1'b0; sub_8 = 1'b0; out_ready_8 = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_sweep32();
        test_sweep8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. Operands are skewed across register stages so each stage resolves `GPS` groups using the registered carry from the previous stage. The block sits in the datapath wherever wide additions must close timing at high clock rates. It carries a valid/ready handshake with full backpressure, a subtract mode, and carry and signed-overflow flags.

## Interface
- `WIDTH`, 16: operand width in bits; must be a multiple of `4*GPS`.
- `GPS`, 1: 4-bit groups resolved per pipeline stage.
- `NSTG` (derived, localparam): `WIDTH/(4*GPS)`, the pipeline depth.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  block accepts input this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry in; ignored when `sub`=1.
- `sub`  in  1  1: compute a − b (b inverted, carry-in forced to 1).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- `ovf`  out  1  signed overflow.

## Operation
- Effective operands: `bb = sub ? ~b : b` and `c0 = sub ? 1 : cin`, both computed at the input.
- Each group uses `p=a^b` and `g=a&b` per bit.
  - Carries: `c[i+1] = g[i] | p[i]&c[i]`, fully expanded within the group. No ripple inside a group.
  - Sum: `s[i] = p[i]^c[i]`.
  - Group carry-out expansion: `g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0`.
- Stage k (0..NSTG−1) resolves bits `[4*GPS*(k+1)-1 : 4*GPS*k]` from operand bits held in stage k's input register and the carry registered by stage k−1. Stage 0 uses `c0`.
- Skew: unresolved upper operand bits travel forward with the transaction. Resolved sum bits travel forward to the output. Each stage's register holds only the bits still needed.
- `ovf` = carry into MSB XOR carry out of MSB. It is computed in the last stage.
- Each stage register has a valid bit.
- Pipeline advance: `adv = !out_valid | out_ready`. It is global, so all stages shift together and there is no bubble collapse.
- `in_ready = adv`, combinational from `out_valid` and `out_ready`.
- A transfer occurs on `in_valid & in_ready`. When `adv`=1 and `in_valid`=0, a bubble (valid=0) enters stage 0.
- While `adv`=0, all registers hold and the outputs stay stable.
- Outputs come straight from the last stage register. There is no combinational path from `a`, `b` or `cin` to the outputs.
- Reset (asynchronous, any time, including mid-flight):
  - All valid bits go to 0 and in-flight transactions are dropped.
  - `sum`, `cout`, `ovf` and every data register go to 0.
  - `out_valid` goes to 0, so `in_ready` is 1 once reset has been applied.

## Timing
- Latency: exactly `NSTG` cycles from the accepting edge to `out_valid`=1 when never stalled. Default is 4 cycles.
- Throughput: one transaction per cycle with `out_ready` held at 1.
- A stall of n cycles adds n cycles to the latency of every in-flight transaction.
- Order is preserved and no transaction is dropped or duplicated.
- `out_valid & !out_ready` holds `sum`, `cout` and `ovf` stable until the handshake completes.
- Simultaneous output handshake and input accept in the same cycle are both legal and both happen.
- `NSTG`=1 (e.g. `WIDTH=4, GPS=1`): single register stage, latency 1.

## Structure
- Shared package `cla_pkg`:
  - `GRP_W = 4`.
  - A function computing group carries and sums (p, g, cin → sum[3:0], cout).
  - The `WIDTH % (4*GPS) == 0` check constant, used by an elaboration-time assertion.
- One sub-module `cla_grp4`: combinational 4-bit lookahead group with ports a, b, cin → sum, cout, gp, gg (group propagate/generate). It is instantiated `GPS` times per stage with an internal group-level lookahead across the `GPS` groups.
- Top `cla_pipe_adder` holds the generate loop over stages, the skew/deskew registers and the handshake.

## Test plan
- Defaults, `out_ready`=1: send `a=16'hFFFF, b=16'h0001, cin=0, sub=0` → after 4 cycles `sum=16'h0000, cout=1, ovf=0`.
- Subtract: send `a=16'h8000, b=16'h0001, sub=1` → `sum=16'h7FFF, cout=1, ovf=1`. Then send `a=16'h0001, b=16'h0002, sub=1` → `sum=16'hFFFF, cout=0, ovf=0`.
- Back-to-back: send 8 consecutive random transactions with `out_ready`=1 → 8 results on consecutive cycles, in order, each matching `a+b+cin` in a reference model.
- Backpressure: with 4 in flight, drop `out_ready` for 3 cycles →
  - `in_ready`=0;
  - the head result stays stable;
  - on release, all 4 results emerge in order with none lost.
- Reset mid-flight: assert `rst_n`=0 with 3 transactions in flight →
  - immediately `out_valid=0`, `sum=0`, `cout=0`, `ovf=0`;
  - after release, a new transaction `a=16'h7FFF, b=16'h0001` → `sum=16'h8000, ovf=1` after 4 cycles, and no stale results appear.
- Parameter sweep `WIDTH=32, GPS=2` (`NSTG`=4) and `WIDTH=8, GPS=2` (`NSTG`=1) →
  - exhaustive/random compare against `a±b` with latency equal to `NSTG`;
  - include `cin=1` with all-ones operands.
